l1c_inst_sa: RTL and testbench
==============================

Name: l1c_inst_sa

Overview:
- Parametrised, read-only, set-associative instruction cache between the CPU fetch port and the CPU wrapper's memory-side word port.
- Supports 1 or 2 ways with per-set LRU replacement and a configurable line size.
- Refills critical-word-first with wrap-around; the core is answered once the line is complete.
- Adds a whole-cache flush input and hit/miss event counters. Tag, valid and data storage are internal register arrays.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width
SETS, 64, number of sets (power of 2, >=2); INDEX_W=log2(SETS)
LINE_WORDS, 4, words per line (power of 2, >=2); OFF_W=log2(LINE_WORDS)
WAYS, 2, associativity, legal values 1 or 2
TAG_W = ADDR_W-INDEX_W-OFF_W-2 (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
core_req  in  1  fetch request, held until the core_wait=0 response cycle
core_addr  in  ADDR_W  fetch byte address; bits[1:0] ignored
core_wait  out  1  core must stall while 1
core_out  out  DATA_W  fetched word, valid when core_wait=0 in DONE
flush  in  1  pulse: invalidate all lines
mem_req  out  1  refill word request
mem_addr  out  ADDR_W  refill word address
mem_out  in  DATA_W  refill data, valid when mem_req && !mem_wait
mem_wait  in  1  memory not ready; a beat completes on mem_req && !mem_wait
hit_cnt  out  32  lookups that hit, wraps
miss_cnt  out  32  lookups that missed, wraps

Behaviour:
- Address split:
  - tag = addr[ADDR_W-1 -: TAG_W]
  - index = addr[INDEX_W+OFF_W+1 : OFF_W+2]
  - word offset = addr[OFF_W+1:2]
- Reset values:
  - state IDLE; all valid=0; all LRU bits=0; counters=0; flush_pending=0.
  - mem_req=0, mem_addr=0, core_out=0.
  - core_wait=0 (with core_req=0).
- States: IDLE, LOOKUP, REFILL, DONE.
- IDLE:
  - core_wait = core_req || flush.
  - If flush or flush_pending: clear all valid and LRU, clear flush_pending, stay in IDLE; a simultaneous core_req is not accepted.
  - Otherwise core_req latches the address into req_addr and moves to LOOKUP.
- LOOKUP:
  - core_wait=1. Compare the tag against every valid way of the set.
  - Hit: core_out <= matching word; lru[set] <= the other way (WAYS=2); hit_cnt++; go to DONE.
  - Miss: miss_cnt++; beat counter = word offset; choose victim and go to REFILL.
  - Victim selection (WAYS=2): first invalid way, way0 checked first; if both ways are valid, the way given by lru[set]. WAYS=1: way0.
- REFILL:
  - core_wait=1, mem_req=1.
  - mem_addr = {req tag, index, beat counter, 2'b00}.
  - Each completed beat writes mem_out into victim way, word = beat counter; the counter then increments modulo LINE_WORDS (wraps line end -> word 0).
  - The first beat also loads core_out (critical word).
  - mem_wait=1: mem_addr held, nothing captured.
  - After LINE_WORDS beats: write victim tag, valid=1, lru[set] <= other way, go to DONE.
  - The victim valid bit is cleared on entering REFILL, so a partial line is never valid.
- DONE:
  - Exactly one cycle: core_wait=0, core_out held, mem_req=0, then IDLE.
  - core_req in DONE is treated as the already-answered request. A new fetch is accepted in IDLE the following cycle.
- Latency:
  - hit: request sampled in IDLE, response 2 cycles later.
  - miss: 2 + LINE_WORDS + total mem_wait cycles.
- flush outside IDLE sets flush_pending. The in-flight request completes normally and returns its data; invalidation happens on the next IDLE cycle, so the just-filled line is also invalidated.
- Async rst mid-refill: mem_req drops immediately, state returns to IDLE, partial line discarded, all lines invalid.
- core_out only changes in LOOKUP (hit) or on the first refill beat.

Test Plan:
- Cold miss, fetch 0x108 (index 0x10, offset 2), mem_out = 0xA0+word:
  - mem_addr sequence must be 0x108, 0x10C, 0x100, 0x104.
  - core_out=0xA2 in DONE; miss_cnt=1.
  - Then fetch 0x100: core_out=0xA0 two cycles after request, mem_req stays 0, hit_cnt=1.
- mem_wait=1 for 3 cycles on the second beat:
  - mem_addr stays 0x10C for 4 cycles, that word is captured only once, no other beat is captured during the stall.
  - Total miss latency 2+4+3=9 cycles.
- LRU (WAYS=2):
  - Fill 0x108 then 0x508 (same set, both ways valid); fetch 0x508 again (hit).
  - Fetch 0x908 must evict 0x108.
  - Then 0x508 hits and 0x108 misses.
- Flush asserted during a refill beat of 0x108:
  - core_out still returns the critical word and mem_req stops after the line.
  - The next cycle clears valid; the following fetch of 0x108 misses.
- rst pulsed during REFILL: mem_req=0 immediately, hit_cnt=miss_cnt=0; a subsequent fetch of the same address misses.
- WAYS=1, SETS=4, LINE_WORDS=2:
  - Fetch 0x00 then 0x20 (same set): second fetch evicts the first.
  - Refetch 0x00 misses; mem_addr sequence for 0x04 is 0x04, 0x00.

Source files
------------

// File: rtl/l1c_inst_sa.sv
// Read-only 1/2-way set-associative instruction cache with LRU, critical-word-first refill and flush.
// Hit answers 2 cycles after the request; a miss takes 2 + LINE_WORDS + memory stall cycles.
module l1c_inst_sa #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_wait,
  output logic [DATA_W-1:0] core_out,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_wait,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_DONE} state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:2]          r_req_addr;
  logic [WAYS-1:0][SETS-1:0]  r_valid;
  logic [SETS-1:0]            r_lru;
  logic [TAG_W-1:0]           r_tag  [WAYS][SETS];
  logic [DATA_W-1:0]          r_data [WAYS][SETS][LINE_WORDS];
  logic                       r_flush_pending;
  logic [OFF_W-1:0]           r_beat;
  logic [OFF_W-1:0]           r_cnt;
  logic                       r_victim;
  logic [DATA_W-1:0]          r_core_out;
  logic [31:0]                r_hit_cnt;
  logic [31:0]                r_miss_cnt;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic [OFF_W-1:0]   w_off;
  logic               w_hit;
  logic               w_hit_way;
  logic [DATA_W-1:0]  w_hit_dat;
  logic               w_victim;
  logic               w_flush_now;
  logic               w_beat_ok;
  logic               w_last;
  logic               w_unused;

  assign w_unused    = ^core_addr[1:0];
  assign w_tag       = r_req_addr[ADDR_W-1 -: TAG_W];
  assign w_idx       = r_req_addr[INDEX_W+OFF_W+1 : OFF_W+2];
  assign w_off       = r_req_addr[OFF_W+1:2];
  assign w_flush_now = flush | r_flush_pending;
  assign w_beat_ok   = mem_req & ~mem_wait;
  assign w_last      = &r_cnt;

  assign core_out = r_core_out;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign mem_addr = (r_state == S_REFILL) ? {w_tag, w_idx, r_beat, 2'b00} : '0;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    w_hit_dat = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
        w_hit_dat = r_data[w][w_idx][w_off];
      end
    end
  end

  // Victim: first invalid way (way0 first), otherwise the LRU way.
  generate
    if (WAYS == 1) begin : g_one_way
      assign w_victim = 1'b0;
    end else begin : g_two_way
      assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                        !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    core_wait = 1'b0;
    mem_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        core_wait = core_req | flush;
        if (!w_flush_now && core_req) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        core_wait = 1'b1;
        w_next    = w_hit ? S_DONE : S_REFILL;
      end
      S_REFILL: begin
        core_wait = 1'b1;
        mem_req   = 1'b1;
        if (w_beat_ok && w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_addr      <= '0;
      r_valid         <= '0;
      r_lru           <= '0;
      r_flush_pending <= 1'b0;
      r_beat          <= '0;
      r_cnt           <= '0;
      r_victim        <= 1'b0;
      r_core_out      <= '0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
    end else begin
      // A flush seen mid-transaction is deferred to the next IDLE cycle.
      if (r_state != S_IDLE && flush) r_flush_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_flush_now) begin
            r_valid         <= '0;
            r_lru           <= '0;
            r_flush_pending <= 1'b0;
          end else if (core_req) begin
            r_req_addr <= core_addr[ADDR_W-1:2];
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_core_out <= w_hit_dat;
            r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (WAYS == 2) r_lru[w_idx] <= ~w_hit_way;
          end else begin
            r_miss_cnt                <= r_miss_cnt + 32'd1;
            r_beat                    <= w_off;
            r_cnt                     <= '0;
            r_victim                  <= w_victim;
            r_valid[w_victim][w_idx]  <= 1'b0;
          end
        end
        S_REFILL: begin
          if (w_beat_ok) begin
            if (r_cnt == '0) r_core_out <= mem_out;
            r_beat <= r_beat + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_valid[r_victim][w_idx] <= 1'b1;
              if (WAYS == 2) r_lru[w_idx] <= ~r_victim;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_ok) begin
      r_data[r_victim][w_idx][r_beat] <= mem_out;
      if (w_last) r_tag[r_victim][w_idx] <= w_tag;
    end
  end

endmodule

// File: tb/tb_l1c_inst_sa.sv
// Bench for l1c_inst_sa: a 2-way/64-set/4-word instance and a 1-way/4-set/2-word instance,
// directed vector table, flush/reset sequences and randomized fetches against an LRU line model.
module tb_l1c_inst_sa;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        core_req  = 1'b0;
  logic [31:0] core_addr = '0;
  logic        flush     = 1'b0;
  logic        mem_wait  = 1'b0;
  logic        sel       = 1'b0;

  logic        req0, flush0, cw0, mreq0;
  logic [31:0] out0, maddr0, mout0, hit0, miss0;
  logic        req1, flush1, cw1, mreq1;
  logic [31:0] out1, maddr1, mout1, hit1, miss1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  assign req0   = core_req & ~sel;
  assign req1   = core_req & sel;
  assign flush0 = flush & ~sel;
  assign flush1 = flush & sel;
  assign mout0  = mem_wait ? 32'hDEADBEEF : mem_word(maddr0);
  assign mout1  = mem_wait ? 32'hDEADBEEF : mem_word(maddr1);

  l1c_inst_sa dut0 (
    .clk(clk), .rst(rst), .core_req(req0), .core_addr(core_addr), .core_wait(cw0),
    .core_out(out0), .flush(flush0), .mem_req(mreq0), .mem_addr(maddr0), .mem_out(mout0),
    .mem_wait(mem_wait), .hit_cnt(hit0), .miss_cnt(miss0)
  );

  l1c_inst_sa #(.SETS(4), .LINE_WORDS(2), .WAYS(1)) dut1 (
    .clk(clk), .rst(rst), .core_req(req1), .core_addr(core_addr), .core_wait(cw1),
    .core_out(out1), .flush(flush1), .mem_req(mreq1), .mem_addr(maddr1), .mem_out(mout1),
    .mem_wait(mem_wait), .hit_cnt(hit1), .miss_cnt(miss1)
  );

  logic        o_wait, o_mreq;
  logic [31:0] o_out, o_maddr;
  assign o_wait  = sel ? cw1 : cw0;
  assign o_mreq  = sel ? mreq1 : mreq0;
  assign o_out   = sel ? out1 : out0;
  assign o_maddr = sel ? maddr1 : maddr0;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: per set, resident line addresses ordered most- to least-recently used.
  logic [31:0] m_line [2][64][2];
  int          m_cnt  [2][64];
  int          m_hit  [2];
  int          m_miss [2];

  function automatic void model_reset(input bit s);
    for (int i = 0; i < 64; i++) m_cnt[s][i] = 0;
  endfunction

  function automatic bit model_access(input bit s, input logic [31:0] a);
    int          ways, sets, set, k;
    logic [31:0] line;
    ways = s ? 1 : 2;
    sets = s ? 4 : 64;
    line = a >> (s ? 3 : 4);
    set  = int'(line % sets);
    k    = -1;
    for (int i = 0; i < m_cnt[s][set]; i++) if (m_line[s][set][i] == line) k = i;
    if (k >= 0) begin
      for (int j = k; j > 0; j--) m_line[s][set][j] = m_line[s][set][j-1];
      m_line[s][set][0] = line;
      m_hit[s]++;
      return 1'b1;
    end
    if (m_cnt[s][set] < ways) m_cnt[s][set]++;
    for (int j = m_cnt[s][set] - 1; j > 0; j--) m_line[s][set][j] = m_line[s][set][j-1];
    m_line[s][set][0] = line;
    m_miss[s]++;
    return 1'b0;
  endfunction

  // One fetch: request in IDLE, drive mem_wait per beat, record the observed refill beats.
  task automatic fetch(input bit s, input logic [31:0] a, input int stall_beat, input int stall_len,
                       input bit rnd, input int flush_at, output logic [31:0] dat, output int lat,
                       output bit miss, output bit seq_ok, output int nstall, output bit done);
    int          beat, lw, off;
    logic [31:0] base, exp_a;
    lw   = s ? 2 : 4;
    base = a & ~(32'(lw * 4) - 32'd1);
    off  = int'((a >> 2) % lw);
    @(negedge clk);
    sel = s; core_addr = a; core_req = 1'b1; mem_wait = 1'b0;
    beat = 0; lat = 0; miss = 1'b0; seq_ok = 1'b1; nstall = 0; done = 1'b0; dat = '0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      flush = (flush_at > 0) && (lat == flush_at);
      if (!o_wait) begin
        done = 1'b1; dat = o_out; core_req = 1'b0; mem_wait = 1'b0;
      end else if (o_mreq) begin
        miss  = 1'b1;
        exp_a = base + 32'(((off + beat) % lw) * 4);
        if (o_maddr !== exp_a) seq_ok = 1'b0;
        if (rnd) mem_wait = ($urandom_range(0, 3) == 0);
        else     mem_wait = (beat == stall_beat) && (nstall < stall_len);
        if (mem_wait) nstall++;
        else          beat++;
      end else begin
        mem_wait = 1'b0;
      end
    end
    flush = 1'b0; core_req = 1'b0; mem_wait = 1'b0;
    if (beat != (miss ? lw : 0)) seq_ok = 1'b0;
  endtask

  // elat < 0 means: derive latency from the hit/miss rule and the stalls actually inserted.
  task automatic run(input string nm, input bit s, input logic [31:0] a, input int sb, input int sl,
                     input bit rnd, input int fa, input logic [31:0] ed, input bit eh, input int elat);
    logic [31:0] dat;
    int          lat, nstall, want;
    bit          miss, seq_ok, done;
    fetch(s, a, sb, sl, rnd, fa, dat, lat, miss, seq_ok, nstall, done);
    want = (elat >= 0) ? elat : (eh ? 2 : 2 + (s ? 2 : 4) + nstall);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_data"}, dat, ed);
    chk({nm, "_miss"}, 32'(miss), 32'(!eh));
    chk({nm, "_memseq"}, 32'(seq_ok), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(want));
  endtask

  task automatic idle_flush(input bit s);
    @(negedge clk);
    sel = s; flush = 1'b1;
    #1 chk("flush_core_wait", 32'(o_wait), 32'd1);
    @(negedge clk);
    flush = 1'b0;
  endtask

  typedef struct {
    bit          s;
    logic [31:0] addr;
    int          stall_beat;
    int          stall_len;
    logic [31:0] exp_dat;
    bit          exp_hit;
    int          exp_lat;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [31:0] a;
    bit          s, eh;

    vt[0]  = '{1'b0, 32'h108, 1, 3, 32'hA2,  1'b0, 9};
    vt[1]  = '{1'b0, 32'h100, -1, 0, 32'hA0,  1'b1, 2};
    vt[2]  = '{1'b0, 32'h508, -1, 0, 32'h1A2, 1'b0, 6};
    vt[3]  = '{1'b0, 32'h508, -1, 0, 32'h1A2, 1'b1, 2};
    vt[4]  = '{1'b0, 32'h908, -1, 0, 32'h2A2, 1'b0, 6};
    vt[5]  = '{1'b0, 32'h50C, -1, 0, 32'h1A3, 1'b1, 2};
    vt[6]  = '{1'b0, 32'h108, -1, 0, 32'hA2,  1'b0, 6};
    vt[7]  = '{1'b0, 32'h904, -1, 0, 32'h2A1, 1'b0, 6};
    vt[8]  = '{1'b0, 32'h10C, -1, 0, 32'hA3,  1'b1, 2};
    vt[9]  = '{1'b1, 32'h00,  -1, 0, 32'h60,  1'b0, 4};
    vt[10] = '{1'b1, 32'h20,  -1, 0, 32'h68,  1'b0, 4};
    vt[11] = '{1'b1, 32'h04,  -1, 0, 32'h61,  1'b0, 4};
    vt[12] = '{1'b1, 32'h00,  -1, 0, 32'h60,  1'b1, 2};
    vt[13] = '{1'b1, 32'h20,  -1, 0, 32'h68,  1'b0, 4};

    model_reset(0); model_reset(1);
    m_hit = '{0, 0}; m_miss = '{0, 0};

    repeat (2) @(negedge clk);
    chk("rst_core_wait0", 32'(cw0), 32'd0);
    chk("rst_mem_req0", 32'(mreq0), 32'd0);
    chk("rst_mem_addr0", maddr0, 32'd0);
    chk("rst_core_out0", out0, 32'd0);
    chk("rst_hit_cnt0", hit0, 32'd0);
    chk("rst_miss_cnt0", miss0, 32'd0);
    chk("rst_core_out1", out1, 32'd0);
    chk("rst_core_wait1", 32'(cw1), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      void'(model_access(vt[i].s, vt[i].addr));
      run($sformatf("vec%0d", i), vt[i].s, vt[i].addr, vt[i].stall_beat, vt[i].stall_len,
          1'b0, 0, vt[i].exp_dat, vt[i].exp_hit, vt[i].exp_lat);
    end
    chk("vec_hit_cnt0", hit0, 32'd4);
    chk("vec_miss_cnt0", miss0, 32'd5);
    chk("vec_hit_cnt1", hit1, 32'd1);
    chk("vec_miss_cnt1", miss1, 32'd4);

    // Flush in IDLE, then a flush during a refill beat: the data still returns, the line is dropped.
    idle_flush(0);
    model_reset(0);
    void'(model_access(0, 32'h10C));
    run("flush_mid", 0, 32'h10C, -1, 0, 1'b0, 3, 32'hA3, 1'b0, 6);
    model_reset(0);
    void'(model_access(0, 32'h108));
    run("flush_after", 0, 32'h108, -1, 0, 1'b0, 0, 32'hA2, 1'b0, 7);
    void'(model_access(0, 32'h108));
    run("flush_rehit", 0, 32'h108, -1, 0, 1'b0, 0, 32'hA2, 1'b1, 2);

    // Asynchronous reset in the middle of a refill.
    @(negedge clk);
    sel = 1'b0; core_addr = 32'h3008; core_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_mem_req_before", 32'(mreq0), 32'd1);
    rst = 1'b1; core_req = 1'b0;
    #1;
    chk("rstmid_mem_req", 32'(mreq0), 32'd0);
    chk("rstmid_mem_addr", maddr0, 32'd0);
    chk("rstmid_core_wait", 32'(cw0), 32'd0);
    chk("rstmid_hit_cnt", hit0, 32'd0);
    chk("rstmid_miss_cnt", miss0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset(0); model_reset(1);
    m_hit = '{0, 0}; m_miss = '{0, 0};
    void'(model_access(0, 32'h3008));
    run("rstmid_refetch", 0, 32'h3008, -1, 0, 1'b0, 0, 32'hC62, 1'b0, 6);
    void'(model_access(0, 32'h108));
    run("rstmid_old_line", 0, 32'h108, -1, 0, 1'b0, 0, 32'hA2, 1'b0, 6);

    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        idle_flush(s);
        model_reset(s);
      end
      if (!s) a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                  (32'($urandom_range(0, 3)) << 2);
      else    a = (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 3)) << 3) |
                  (32'($urandom_range(0, 1)) << 2);
      eh = model_access(s, a);
      run($sformatf("rnd%0d", i), s, a, -1, 0, 1'b1, 0, mem_word(a), eh, -1);
    end
    chk("final_hit_cnt0", hit0, 32'(m_hit[0]));
    chk("final_miss_cnt0", miss0, 32'(m_miss[0]));
    chk("final_hit_cnt1", hit1, 32'(m_hit[1]));
    chk("final_miss_cnt1", miss1, 32'(m_miss[1]));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
